i2c_cmd_arbiter: RTL and testbench

- Shares one I2C master engine among N_REQ on-chip requesters. Each requester issues single-byte register read/write commands.
- Arbitrates round-robin, latches the winning command, and holds the master's command inputs stable for the whole transaction.
- Pulses the master's start and waits for completion or timeout, then returns status and read data to the winning requester.
- Sits between the system-side clients and the I2C master.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_rr_pick.sv | 33 +++
 rtl/i2c_cmd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command arbiter: FSM encoding, response
// error codes, command field widths and the round-robin index helper.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int DEV_W  = 7;
    localparam int REG_W  = 8;
    localparam int DATA_W = 8;

    // (base + off) mod n, assuming base < n and off < n.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off, input int n);
        int s;
        s = int'({29'd0, base}) + off;
        if (s >= n) begin
            s = s - n;
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo N_REQ.
module i2c_rr_pick
    import i2c_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic             o_valid,
    output logic [2:0]       o_idx
);

    logic [7:0] w_req8;

    always_comb begin
        w_req8 = '0;
        w_req8[N_REQ-1:0] = i_req;
    end

    // Walk offsets from the far end so the nearest offset overwrites last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_req8[wrap_add(i_ptr, k, N_REQ)]) begin
                o_valid = 1'b1;
                o_idx   = wrap_add(i_ptr, k, N_REQ);
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ requesters; holds
// the granted command stable and returns status/read data to the winner.
module i2c_cmd_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TO_W        = 12,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_rw,
    input  logic [DEV_W*N_REQ-1:0]  req_dev,
    input  logic [REG_W*N_REQ-1:0]  req_reg,
    input  logic [DATA_W*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rsp_valid,
    output logic [2:0]              rsp_id,
    output logic [1:0]              rsp_err,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    busy,
    output logic                    m_start,
    output logic                    m_rw,
    output logic [DEV_W-1:0]        m_dev,
    output logic [REG_W-1:0]        m_reg,
    output logic [DATA_W-1:0]       m_wdata,
    input  logic                    m_done,
    input  logic                    m_nack,
    input  logic [DATA_W-1:0]       m_rdata,
    output state_t                  dbg_state
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // Handshake: req[i] is held until gnt[i] pulses; gnt means the command
    // was latched. rsp_valid pulses once per grant unless reset intervenes.
    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_ptr;
    logic [2:0]          r_idx;
    logic [TO_W-1:0]     r_cnt;
    logic [N_REQ-1:0]    r_gnt;
    logic                r_rsp_valid;
    logic [2:0]          r_rsp_id;
    logic [1:0]          r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_busy;
    logic                r_m_start;
    logic                r_m_rw;
    logic [DEV_W-1:0]    r_m_dev;
    logic [REG_W-1:0]    r_m_reg;
    logic [DATA_W-1:0]   r_m_wdata;

    logic                w_pick_valid;
    logic [2:0]          w_pick_idx;
    logic [N_REQ-1:0]    w_gnt_oh;
    logic                w_sel_rw;
    logic [DEV_W-1:0]    w_sel_dev;
    logic [REG_W-1:0]    w_sel_reg;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_to_hit;

    i2c_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_gnt_oh    = '0;
        w_sel_rw    = 1'b0;
        w_sel_dev   = '0;
        w_sel_reg   = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == i[2:0]) begin
                w_gnt_oh[i] = 1'b1;
                w_sel_rw    = req_rw[i];
                w_sel_dev   = req_dev[DEV_W*i +: DEV_W];
                w_sel_reg   = req_reg[REG_W*i +: REG_W];
                w_sel_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign w_to_hit = (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (m_done || w_to_hit) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Response fields are registered on leaving WAIT so rsp_valid is seen
    // during the RESP cycle, one edge after m_done is sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_err   <= ERR_OK;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b0;
            r_m_start   <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_dev     <= '0;
            r_m_reg     <= '0;
            r_m_wdata   <= '0;
        end else begin
            r_gnt       <= '0;
            r_m_start   <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_idx     <= w_pick_idx;
                        r_m_rw    <= w_sel_rw;
                        r_m_dev   <= w_sel_dev;
                        r_m_reg   <= w_sel_reg;
                        r_m_wdata <= w_sel_wdata;
                        r_gnt     <= w_gnt_oh;
                        r_busy    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_m_start <= 1'b1;
                    r_cnt     <= '0;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (m_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_idx;
                        r_rsp_err   <= m_nack ? ERR_NACK : ERR_OK;
                        r_rsp_rdata <= (r_m_rw && !m_nack) ? m_rdata : '0;
                    end else if (w_to_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_idx;
                        r_rsp_err   <= ERR_TIMEOUT;
                        r_rsp_rdata <= '0;
                    end
                end
                ST_RESP: begin
                    r_busy <= 1'b0;
                    r_ptr  <= (r_idx == 3'(N_REQ - 1)) ? 3'd0 : r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign m_start   = r_m_start;
    assign m_rw      = r_m_rw;
    assign m_dev     = r_m_dev;
    assign m_reg     = r_m_reg;
    assign m_wdata   = r_m_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: table of single transactions plus
// round-robin, timeout, tie and mid-transaction reset sequences.
module tb_i2c_cmd_arbiter;
    import i2c_pkg::*;

    localparam int N   = 4;
    localparam int TOW = 12;
    localparam int TO  = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_rw;
    logic [7*N-1:0]  req_dev;
    logic [8*N-1:0]  req_reg;
    logic [8*N-1:0]  req_wdata;
    logic [N-1:0]    gnt;
    logic            rsp_valid;
    logic [2:0]      rsp_id;
    logic [1:0]      rsp_err;
    logic [7:0]      rsp_rdata;
    logic            busy;
    logic            m_start;
    logic            m_rw;
    logic [6:0]      m_dev;
    logic [7:0]      m_reg;
    logic [7:0]      m_wdata;
    logic            m_done;
    logic            m_nack;
    logic [7:0]      m_rdata;
    state_t          dbg_state;

    int checks = 0;
    int errors = 0;

    i2c_cmd_arbiter #(.N_REQ(N), .TO_W(TOW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
        .m_start(m_start), .m_rw(m_rw), .m_dev(m_dev), .m_reg(m_reg),
        .m_wdata(m_wdata), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       nack;
        logic [7:0] mrd;
        logic [1:0] exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int id, input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        req_rw[id]            = rw;
        req_dev[7*id +: 7]    = dev;
        req_reg[8*id +: 8]    = rg;
        req_wdata[8*id +: 8]  = wd;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        m_done = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_m_start"}, 32'(m_start), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({tag, "_m_cmd"}, {8'd0, m_rw, m_dev, m_reg, m_wdata}, 0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic run_vec(input vec_t v);
        set_cmd(v.id, v.rw, v.dev, v.rg, v.wd);
        req = '0;
        req[v.id] = 1'b1;
        step();
        chk("vec_gnt", 32'(gnt), 32'(1 << v.id));
        chk("vec_busy_at_gnt", 32'(busy), 1);
        chk("vec_no_start_at_gnt", 32'(m_start), 0);
        chk("vec_state_issue", 32'(dbg_state), 32'(ST_ISSUE));
        req = '0;
        step();
        chk("vec_m_start", 32'(m_start), 1);
        chk("vec_gnt_pulse", 32'(gnt), 0);
        chk("vec_m_cmd", {8'd0, m_rw, m_dev, m_reg, m_wdata}, {8'd0, v.rw, v.dev, v.rg, v.wd});
        m_done  = 1'b1;
        m_nack  = v.nack;
        m_rdata = v.mrd;
        step();
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_rdata = 8'h00;
        chk("vec_rsp_valid", 32'(rsp_valid), 1);
        chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        chk("vec_rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("vec_rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rd));
        chk("vec_busy_at_rsp", 32'(busy), 1);
        chk("vec_m_wdata_stable", 32'(m_wdata), 32'(v.wd));
        step();
        chk("vec_rsp_pulse", 32'(rsp_valid), 0);
        chk("vec_busy_drop", 32'(busy), 0);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b0; req = '0; req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;

        vecs[0] = '{id:0, rw:1'b0, dev:7'h50, rg:8'h10, wd:8'hA5, nack:1'b0, mrd:8'h77, exp_err:ERR_OK,   exp_rd:8'h00};
        vecs[1] = '{id:2, rw:1'b1, dev:7'h3A, rg:8'h22, wd:8'h00, nack:1'b0, mrd:8'h3C, exp_err:ERR_OK,   exp_rd:8'h3C};
        vecs[2] = '{id:1, rw:1'b1, dev:7'h21, rg:8'h7F, wd:8'h11, nack:1'b1, mrd:8'h99, exp_err:ERR_NACK, exp_rd:8'h00};
        vecs[3] = '{id:3, rw:1'b0, dev:7'h7F, rg:8'hFF, wd:8'h5A, nack:1'b1, mrd:8'h42, exp_err:ERR_NACK, exp_rd:8'h00};
        vecs[4] = '{id:3, rw:1'b1, dev:7'h01, rg:8'h80, wd:8'hC3, nack:1'b0, mrd:8'hFF, exp_err:ERR_OK,   exp_rd:8'hFF};

        // Reset state, and m_done in IDLE must be ignored.
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b1;
        m_done = 1'b1;
        m_rdata = 8'hEE;
        step();
        m_done = 1'b0;
        m_rdata = 8'h00;
        step();
        chk("idle_done_ignored", 32'(rsp_valid), 0);
        chk("idle_stays", 32'(dbg_state), 32'(ST_IDLE));

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Round-robin with all requests held continuously.
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_cmd(i, 1'b0, 7'h10 + 7'(i), 8'h40 + 8'(i), 8'hB0 + 8'(i));
        end
        req = 4'b1111;
        begin
            int n_gnt = 0;
            int n_rsp = 0;
            int last_rsp = -10;
            int dly = -1;
            for (int cyc = 0; cyc < 300 && n_rsp < 5; cyc++) begin
                step();
                m_done = 1'b0;
                if (gnt != '0) begin
                    if (n_gnt < 5) begin
                        chk("rr_gnt_order", 32'(gnt), 32'(1 << exp_order[n_gnt]));
                    end
                    if (n_gnt > 0) begin
                        chk("rr_gap", cyc - last_rsp, 2);
                    end
                    n_gnt++;
                end
                if (rsp_valid) begin
                    chk("rr_rsp_id", 32'(rsp_id), 32'(exp_order[n_rsp]));
                    chk("rr_no_overlap", 32'(gnt), 0);
                    chk("rr_m_dev_stable", 32'(m_dev), 32'h10 + 32'(exp_order[n_rsp]));
                    last_rsp = cyc;
                    n_rsp++;
                end
                if (m_start) begin
                    dly = 3;
                end else if (dly > 0) begin
                    dly--;
                end
                if (dly == 0) begin
                    m_done = 1'b1;
                    dly = -1;
                end
            end
            chk("rr_complete", n_rsp, 5);
        end
        req = '0;
        m_done = 1'b0;

        // Timeout: no m_done; rsp_valid TO cycles after WAIT is entered.
        do_reset();
        set_cmd(1, 1'b1, 7'h2B, 8'h05, 8'h00);
        req = 4'b0010;
        step();
        req = '0;
        step();
        chk("to_m_start", 32'(m_start), 1);
        begin
            int n = 0;
            for (int k = 1; k <= TO + 5; k++) begin
                step();
                if (rsp_valid) begin
                    n = k;
                    break;
                end
            end
            chk("to_latency", n, TO);
            chk("to_rsp_err", 32'(rsp_err), 32'(ERR_TIMEOUT));
            chk("to_rsp_rdata", 32'(rsp_rdata), 0);
            chk("to_rsp_id", 32'(rsp_id), 1);
        end
        step();

        // Tie: m_done on the timeout terminal cycle wins.
        set_cmd(2, 1'b1, 7'h33, 8'h44, 8'h00);
        req = 4'b0100;
        step();
        req = '0;
        step();
        chk("tie_m_start", 32'(m_start), 1);
        for (int k = 0; k < TO - 1; k++) begin
            step();
        end
        chk("tie_not_early", 32'(rsp_valid), 0);
        m_done = 1'b1;
        m_rdata = 8'h5A;
        step();
        m_done = 1'b0;
        m_rdata = 8'h00;
        chk("tie_rsp_valid", 32'(rsp_valid), 1);
        chk("tie_rsp_err", 32'(rsp_err), 32'(ERR_OK));
        chk("tie_rsp_rdata", 32'(rsp_rdata), 32'h5A);
        step();

        // Reset in WAIT: command dropped, pointer back to 0.
        set_cmd(3, 1'b1, 7'h6E, 8'h99, 8'h00);
        req = 4'b1000;
        step();
        req = '0;
        step();
        step();
        step();
        chk("mid_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b0;
        step();
        chk_all_zero("mid_reset");
        rst = 1'b1;
        m_done = 1'b1;
        m_rdata = 8'hAB;
        step();
        m_done = 1'b0;
        chk("mid_no_rsp", 32'(rsp_valid), 0);
        set_cmd(2, 1'b0, 7'h12, 8'h34, 8'h56);
        req = 4'b1100;
        step();
        chk("mid_ptr_reset_gnt", 32'(gnt), 32'b0100);
        req = '0;
        step();
        chk("mid_new_cmd", {8'd0, m_rw, m_dev, m_reg, m_wdata}, {8'd0, 1'b0, 7'h12, 8'h34, 8'h56});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
